// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_arb_pkg;

  localparam int MEM_AW_DEF = 16;
  localparam int MEM_DW_DEF = 32;

  typedef logic id_t;

  localparam id_t ID_M0 = 1'b0;
  localparam id_t ID_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_idq.sv
// In-order queue of master IDs for outstanding reads; the head names the owner of the next response.
module mem_arb_idq
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  id_t  push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output id_t  head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  id_t           slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A push into a full queue is only legal when a pop frees the head slot in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arb2.sv
// Round-robin arbiter giving m0/m1 a shared single-port memory bus, with in-order read return routing.
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int MEM_DW = MEM_DW_DEF,
  parameter int OUTST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [MEM_AW-1:0] m0_addr,
  input  logic [MEM_DW-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rdata_vld,
  output logic [MEM_DW-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [MEM_AW-1:0] m1_addr,
  input  logic [MEM_DW-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rdata_vld,
  output logic [MEM_DW-1:0] m1_rdata,
  output logic              mem_req,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic              mem_rdata_vld,
  input  logic [MEM_DW-1:0] mem_rdata,
  output logic              err_unexp_rsp
);

  logic              q_full;
  logic              q_empty;
  id_t               q_head;
  id_t               last_gnt;
  logic              m0_elig;
  logic              m1_elig;
  logic              accept;
  id_t               sel_id;
  logic              sel_write;
  logic [MEM_AW-1:0] sel_addr;
  logic [MEM_DW-1:0] sel_wdata;
  logic              push;
  logic              pop;

  // Full comes from the registered count only, so a pop this cycle does not free a slot until next cycle.
  assign m0_elig = rst_n & m0_req & (m0_write | ~q_full);
  assign m1_elig = rst_n & m1_req & (m1_write | ~q_full);

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (m0_elig && m1_elig) begin
      if (last_gnt == ID_M1) m0_gnt = 1'b1;
      else                   m1_gnt = 1'b1;
    end else if (m0_elig) begin
      m0_gnt = 1'b1;
    end else if (m1_elig) begin
      m1_gnt = 1'b1;
    end
  end

  assign accept    = m0_gnt | m1_gnt;
  assign sel_id    = m1_gnt ? ID_M1 : ID_M0;
  assign sel_write = m1_gnt ? m1_write : m0_write;
  assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;

  assign push = accept & ~sel_write;
  assign pop  = mem_rdata_vld & ~q_empty;

  assign m0_rdata_vld = pop & (q_head == ID_M0);
  assign m1_rdata_vld = pop & (q_head == ID_M1);
  assign m0_rdata     = mem_rdata;
  assign m1_rdata     = mem_rdata;

  mem_arb_idq #(.DEPTH(OUTST)) u_idq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (sel_id),
    .pop     (pop),
    .full    (q_full),
    .empty   (q_empty),
    .head    (q_head)
  );

  // last_gnt resets to m1 so that m0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req       <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      last_gnt      <= ID_M1;
      err_unexp_rsp <= 1'b0;
    end else begin
      mem_req   <= accept;
      mem_write <= accept & sel_write;
      if (accept) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        last_gnt  <= sel_id;
      end
      if (mem_rdata_vld && q_empty) err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2 with a fixed-latency memory model returning data == address.
module tb_mem_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rdata_vld, m1_rdata_vld;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdata_vld;
  logic [31:0] mem_rdata;
  logic        err_unexp_rsp;

  logic        model_vld, inj_vld;
  logic [31:0] model_data, inj_data;
  int          lat = 3;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          start;
  } req_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  req_t        q0[$], q1[$];
  rsp_t        rq[$];
  logic [31:0] exp0[$], exp1[$];
  int          glog_id[$], glog_t[$];

  assign mem_rdata_vld = model_vld | inj_vld;
  assign mem_rdata     = inj_vld ? inj_data : model_data;

  always #5 clk = ~clk;

  mem_arb2 #(.MEM_AW(16), .MEM_DW(32), .OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata_vld(m0_rdata_vld), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata_vld(m1_rdata_vld), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata), .err_unexp_rsp(err_unexp_rsp)
  );

  // Memory model: a read seen on mem_req in cycle M responds in cycle M+lat.
  initial begin
    int cyc;
    cyc = 0;
    model_vld = 1'b0;
    model_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      model_vld = 1'b0;
      if (!rst_n) begin
        rq.delete();
      end else begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
          model_vld  = 1'b1;
          model_data = rq[0].data;
          void'(rq.pop_front());
        end
        if (mem_req && !mem_write) rq.push_back('{due: cyc + lat, data: {16'h0, mem_addr}});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    inj_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_traffic(input int max_cycles);
    int          t;
    bit          done;
    logic        pacc, pwr;
    logic [15:0] paddr;
    logic [31:0] pwd;
    glog_id.delete();
    glog_t.delete();
    t = 0;
    done = 0;
    pacc = 1'b0;
    pwr = 1'b0;
    paddr = '0;
    pwd = '0;
    while (!done && t < max_cycles) begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && t >= q0[0].start) begin
        m0_req = 1'b1; m0_write = q0[0].write; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
      end else m0_req = 1'b0;
      if (q1.size() > 0 && t >= q1[0].start) begin
        m1_req = 1'b1; m1_write = q1[0].write; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
      end else m1_req = 1'b0;
      @(negedge clk);
      checks++;
      if (m0_gnt && m1_gnt) begin
        errors++;
        $display("[TB] FAIL dual_gnt t=%0d: m0_gnt=%b m1_gnt=%b, required at most one", t, m0_gnt, m1_gnt);
      end
      checks++;
      if ((m0_gnt && !m0_req) || (m1_gnt && !m1_req)) begin
        errors++;
        $display("[TB] FAIL spurious_gnt t=%0d: gnt=%b%b req=%b%b", t, m1_gnt, m0_gnt, m1_req, m0_req);
      end
      checks++;
      if (mem_req !== pacc) begin
        errors++;
        $display("[TB] FAIL mem_req t=%0d: got %b required %b", t, mem_req, pacc);
      end else if (pacc) begin
        checks++;
        if (mem_write !== pwr || mem_addr !== paddr || (pwr && mem_wdata !== pwd)) begin
          errors++;
          $display("[TB] FAIL mem_bus t=%0d: got w=%b a=%h d=%h required w=%b a=%h d=%h",
                   t, mem_write, mem_addr, mem_wdata, pwr, paddr, pwd);
        end
      end
      pacc = 1'b0;
      if (m0_gnt && m0_req) begin
        glog_id.push_back(0); glog_t.push_back(t);
        pacc = 1'b1; pwr = m0_write; paddr = m0_addr; pwd = m0_wdata;
        if (!m0_write) exp0.push_back({16'h0, m0_addr});
        void'(q0.pop_front());
      end else if (m1_gnt && m1_req) begin
        glog_id.push_back(1); glog_t.push_back(t);
        pacc = 1'b1; pwr = m1_write; paddr = m1_addr; pwd = m1_wdata;
        if (!m1_write) exp1.push_back({16'h0, m1_addr});
        void'(q1.pop_front());
      end
      if (m0_rdata_vld || m1_rdata_vld) begin
        checks++;
        if (m0_rdata_vld && m1_rdata_vld) begin
          errors++;
          $display("[TB] FAIL both_vld t=%0d: m0_rdata_vld=1 m1_rdata_vld=1", t);
        end else if (m0_rdata_vld) begin
          if (exp0.size() == 0) begin
            errors++;
            $display("[TB] FAIL rsp0_unexpected t=%0d: data %h with nothing outstanding", t, m0_rdata);
          end else begin
            if (m0_rdata !== exp0[0]) begin
              errors++;
              $display("[TB] FAIL rsp0_data t=%0d: got %h required %h", t, m0_rdata, exp0[0]);
            end
            void'(exp0.pop_front());
          end
        end else begin
          if (exp1.size() == 0) begin
            errors++;
            $display("[TB] FAIL rsp1_unexpected t=%0d: data %h with nothing outstanding", t, m1_rdata);
          end else begin
            if (m1_rdata !== exp1[0]) begin
              errors++;
              $display("[TB] FAIL rsp1_data t=%0d: got %h required %h", t, m1_rdata, exp1[0]);
            end
            void'(exp1.pop_front());
          end
        end
      end
      t++;
      done = (q0.size() == 0) && (q1.size() == 0) && (exp0.size() == 0) && (exp1.size() == 0);
    end
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== pacc) begin
      errors++;
      $display("[TB] FAIL mem_req_tail: got %b required %b", mem_req, pacc);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL traffic_timeout: got %0d pending, required 0 within %0d cycles",
               q0.size() + q1.size() + exp0.size() + exp1.size(), max_cycles);
    end
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 16'h0001; m0_wdata = '0;
    m1_req = 1'b1; m1_write = 1'b0; m1_addr = 16'h0002; m1_wdata = '0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_gnt: got %b%b required 00", m1_gnt, m0_gnt);
      end
      checks++;
      if (mem_req !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mem_req: got req=%b write=%b required 0", mem_req, mem_write);
      end
      checks++;
      if (m0_rdata_vld !== 1'b0 || m1_rdata_vld !== 1'b0 || err_unexp_rsp !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_vld_err: got vld=%b%b err=%b required 0", m1_rdata_vld, m0_rdata_vld, err_unexp_rsp);
      end
    end
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_m0_writes();
    int et[4];
    et = '{0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 4; i++)
      q0.push_back('{write: 1'b1, addr: 16'h0300 + 16'(i), wdata: 32'hA000_0000 + 32'(i), start: 0});
    run_traffic(20);
    checks++;
    if (glog_id.size() != 4) begin
      errors++;
      $display("[TB] FAIL wr_log_len: got %0d grants required 4", glog_id.size());
    end
    for (int i = 0; i < 4 && i < glog_id.size(); i++) begin
      checks++;
      if (glog_id[i] !== 0 || glog_t[i] !== et[i]) begin
        errors++;
        $display("[TB] FAIL wr_grant%0d: got m%0d@%0d required m0@%0d", i, glog_id[i], glog_t[i], et[i]);
      end
    end
  endtask

  task automatic test_alternate();
    int eid[8];
    int et[8];
    eid = '{0, 1, 0, 1, 0, 1, 0, 1};
    et  = '{0, 1, 2, 3, 5, 6, 7, 8};
    do_reset();
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{write: 1'b0, addr: 16'h0100 + 16'(i), wdata: '0, start: 0});
      q1.push_back('{write: 1'b0, addr: 16'h0200 + 16'(i), wdata: '0, start: 0});
    end
    run_traffic(60);
    checks++;
    if (glog_id.size() != 8) begin
      errors++;
      $display("[TB] FAIL alt_log_len: got %0d grants required 8", glog_id.size());
    end
    for (int i = 0; i < 8 && i < glog_id.size(); i++) begin
      checks++;
      if (glog_id[i] !== eid[i] || glog_t[i] !== et[i]) begin
        errors++;
        $display("[TB] FAIL alt_grant%0d: got m%0d@%0d required m%0d@%0d", i, glog_id[i], glog_t[i], eid[i], et[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    int eid[7];
    int et[7];
    eid = '{0, 0, 0, 0, 1, 0, 0};
    et  = '{0, 1, 2, 3, 6, 12, 13};
    do_reset();
    lat = 10;
    for (int i = 0; i < 6; i++)
      q0.push_back('{write: 1'b0, addr: 16'h0010 + 16'(i), wdata: '0, start: 0});
    q1.push_back('{write: 1'b1, addr: 16'h03F0, wdata: 32'h55AA_0001, start: 6});
    run_traffic(80);
    checks++;
    if (glog_id.size() != 7) begin
      errors++;
      $display("[TB] FAIL full_log_len: got %0d grants required 7", glog_id.size());
    end
    for (int i = 0; i < 7 && i < glog_id.size(); i++) begin
      checks++;
      if (glog_id[i] !== eid[i] || glog_t[i] !== et[i]) begin
        errors++;
        $display("[TB] FAIL full_grant%0d: got m%0d@%0d required m%0d@%0d", i, glog_id[i], glog_t[i], eid[i], et[i]);
      end
    end
  endtask

  task automatic test_push_pop();
    int eid[6];
    int et[6];
    eid = '{0, 1, 0, 1, 0, 1};
    et  = '{0, 1, 2, 3, 6, 7};
    do_reset();
    lat = 4;
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{write: 1'b0, addr: 16'h0400 + 16'(i), wdata: '0, start: 0});
      q1.push_back('{write: 1'b0, addr: 16'h0500 + 16'(i), wdata: '0, start: 0});
    end
    run_traffic(60);
    checks++;
    if (glog_id.size() != 6) begin
      errors++;
      $display("[TB] FAIL pp_log_len: got %0d grants required 6", glog_id.size());
    end
    for (int i = 0; i < 6 && i < glog_id.size(); i++) begin
      checks++;
      if (glog_id[i] !== eid[i] || glog_t[i] !== et[i]) begin
        errors++;
        $display("[TB] FAIL pp_grant%0d: got m%0d@%0d required m%0d@%0d", i, glog_id[i], glog_t[i], eid[i], et[i]);
      end
    end
  endtask

  task automatic test_unexp_rsp();
    do_reset();
    @(posedge clk);
    #1;
    inj_vld = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (m0_rdata_vld !== 1'b0 || m1_rdata_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unexp_vld: got %b%b required 00", m1_rdata_vld, m0_rdata_vld);
    end
    checks++;
    if (err_unexp_rsp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unexp_err_early: got %b required 0 before the clock edge", err_unexp_rsp);
    end
    @(posedge clk);
    #1;
    inj_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp_rsp !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unexp_err_set: got %b required 1", err_unexp_rsp);
    end
    lat = 2;
    q0.push_back('{write: 1'b0, addr: 16'h0040, wdata: '0, start: 0});
    run_traffic(20);
    checks++;
    if (err_unexp_rsp !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unexp_err_sticky: got %b required 1", err_unexp_rsp);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexp_rsp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unexp_err_reset: got %b required 0", err_unexp_rsp);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    inj_vld = 1'b0;
    inj_data = '0;
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    $display("[TB] start");
    test_reset();
    test_m0_writes();
    test_alternate();
    test_full_stall();
    test_push_pop();
    test_unexp_rsp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
